// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch path (IF) and
// the load/store path (DM). One transaction at a time runs through the
// IDLE -> ACCESS -> DONE sequence. When both paths request at once, the
// grant alternates between them. A watchdog ends any access whose memory
// ack never arrives and records that in a sticky error flag.
//
// Handshake: a requester holds its req (and its addr/we/wdata) until it sees
// its done pulse. The gnt pulse marks the cycle in which the request was
// accepted. The done pulse marks completion, and rdata is valid with it.
// On the memory side, mem_en stays high for the whole access, with
// mem_addr/mem_we/mem_wdata stable. mem_ack is only looked at while the
// access is in flight; an ack at any other time is ignored.
module mem_port_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 19,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              err_clr,
  output logic              busy,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // The watchdog counts the ACCESS edges that have passed without an ack.
  // The access is aborted on the edge that would bring the count to
  // TIMEOUT, so the counter never has to hold TIMEOUT itself.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            owner_dm;       // owner of the transaction in flight
  logic            last_owner_dm;  // owner of the most recent grant (0 = IF)
  logic            pick_dm;

  assign dbg_state = state;

  // A lone request wins. When both request, the side that was not granted
  // last time wins.
  always_comb begin
    pick_dm = 1'b0;
    if (dm_req && !if_req) begin
      pick_dm = 1'b1;
    end else if (dm_req && if_req) begin
      pick_dm = !last_owner_dm;
    end
  end

  // Transaction sequencer: grant, memory access with watchdog, done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      wd_cnt        <= '0;
      owner_dm      <= 1'b0;
      last_owner_dm <= 1'b0;
      if_gnt        <= 1'b0;
      if_done       <= 1'b0;
      dm_gnt        <= 1'b0;
      dm_done       <= 1'b0;
      rdata         <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      if_gnt  <= 1'b0;
      dm_gnt  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      // A watchdog abort later in this block overrides the clear.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (if_req || dm_req) begin
            owner_dm      <= pick_dm;
            last_owner_dm <= pick_dm;
            mem_en        <= 1'b1;
            busy          <= 1'b1;
            wd_cnt        <= '0;
            state         <= S_ACCESS;
            if (pick_dm) begin
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
              dm_gnt    <= 1'b1;
            end else begin
              // Fetches are always reads.
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              if_gnt    <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            // Stores leave the last read data in place.
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= S_DONE;
            if (owner_dm) dm_done <= 1'b1;
            else          if_done <= 1'b1;
          end else if (wd_cnt == WD_LAST) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            rdata       <= '0;
            timeout_err <= 1'b1;
            state       <= S_DONE;
            if (owner_dm) dm_done <= 1'b1;
            else          if_done <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
